// File: rtl/fetch_unit_nwide.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_nwide
// Brief    : N-wide block-aligned instruction fetch with redirect, stall and
//            a one-block hold buffer. FETCH_PERF_CNT_EN adds perf counters.
// Revision : 1.0
// ============================================================================
module fetch_unit_nwide #(
    parameter int               FETCH_WIDTH = 2,
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          jump,
    input  logic                          jump_accept,
    input  logic [XLEN-1:0]               jump_addr,
    input  logic                          stop_fetch,
    output logic                          imem_req,
    output logic [XLEN-1:0]               imem_addr,
    input  logic [FETCH_WIDTH*32-1:0]     imem_rdata,
    output logic [FETCH_WIDTH*2*XLEN-1:0] fetch_instr_pc,
    output logic [FETCH_WIDTH-1:0]        fetch_valid,
    output logic                          write_fifo
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_blocks,
    output logic [31:0]                   perf_redirects
`endif
);

    localparam int              c_off_bits   = $clog2(FETCH_WIDTH) + 2;
    localparam int              c_lane_w     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [XLEN-1:0] c_blk_bytes  = XLEN'(FETCH_WIDTH * 4);
    localparam logic [XLEN-1:0] c_align_mask = ~(c_blk_bytes - XLEN'(1));
    localparam logic [XLEN-1:0] c_word_mask  = ~XLEN'(3);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic [XLEN-1:0]               r_pc;
    logic [XLEN-1:0]               r_resp_pc;
    logic                          r_resp_pending;
    logic [XLEN-1:0]               r_hold_pc;
    logic [FETCH_WIDTH*32-1:0]     r_hold_data;

    logic                          w_redirect;
    logic                          w_emit;
    logic                          w_to_hold;
    logic [XLEN-1:0]               w_src_pc;
    logic [XLEN-1:0]               w_base;
    logic [FETCH_WIDTH*32-1:0]     w_src_data;
    logic [c_lane_w-1:0]           w_offset;
    logic [FETCH_WIDTH-1:0]        w_lane_valid;
    logic [FETCH_WIDTH*2*XLEN-1:0] w_lanes;

    assign w_redirect = jump & jump_accept;
    assign imem_addr  = r_pc & c_align_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Redirect wins over everything; a response arriving under stall parks in HOLD.
    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        w_emit       = 1'b0;
        w_to_hold    = 1'b0;
        if (w_redirect) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    imem_req = ~stop_fetch;
                    if (r_resp_pending) begin
                        if (stop_fetch) begin
                            w_to_hold    = 1'b1;
                            w_state_next = S_HOLD;
                        end else begin
                            w_emit = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stop_fetch) begin
                        w_emit       = 1'b1;
                        w_state_next = S_RUN;
                    end
                end
                default: w_state_next = S_RUN;
            endcase
        end
    end

    assign w_src_pc   = (r_state == S_HOLD) ? r_hold_pc   : r_resp_pc;
    assign w_src_data = (r_state == S_HOLD) ? r_hold_data : imem_rdata;
    assign w_base     = w_src_pc & c_align_mask;

    generate
        if (FETCH_WIDTH > 1) begin : g_offset
            assign w_offset = w_src_pc[c_off_bits-1:2];
        end else begin : g_offset_none
            assign w_offset = '0;
        end
    endgenerate

    // Lanes below the entry offset of a mid-block target are zeroed and masked off.
    generate
        for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
            localparam logic [XLEN-1:0] c_lane_off = XLEN'(4 * i);
            assign w_lane_valid[i] = (c_lane_w'(i) >= w_offset);
            assign w_lanes[2*XLEN*i +: 2*XLEN] = w_lane_valid[i]
                ? {XLEN'(w_src_data[32*i +: 32]), w_base + c_lane_off}
                : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc           <= RESET_PC;
            r_resp_pc      <= '0;
            r_resp_pending <= 1'b0;
            r_hold_pc      <= '0;
            r_hold_data    <= '0;
            fetch_instr_pc <= '0;
            fetch_valid    <= '0;
            write_fifo     <= 1'b0;
        end else begin
            write_fifo     <= w_emit;
            r_resp_pending <= imem_req;
            if (w_emit) begin
                fetch_instr_pc <= w_lanes;
                fetch_valid    <= w_lane_valid;
            end else begin
                fetch_valid    <= '0;
            end
            if (w_to_hold) begin
                r_hold_pc   <= r_resp_pc;
                r_hold_data <= imem_rdata;
            end
            if (w_redirect) begin
                r_pc <= jump_addr & c_word_mask;
            end else if (imem_req) begin
                r_resp_pc <= r_pc;
                r_pc      <= (r_pc & c_align_mask) + c_blk_bytes;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_blocks    <= '0;
            perf_redirects <= '0;
        end else begin
            if (w_emit && (perf_blocks != 32'hFFFF_FFFF)) begin
                perf_blocks <= perf_blocks + 32'd1;
            end
            if (w_redirect && (perf_redirects != 32'hFFFF_FFFF)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_nwide.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit_nwide
// Brief    : Directed + random bench for fetch_unit_nwide (two 2-wide DUTs,
//            RESET_PC 0 and 0xFFFF_FFF8) against a block-level model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit_nwide;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        jump = 1'b0;
    logic        jump_accept = 1'b0;
    logic        stop_fetch = 1'b0;
    logic [31:0] jump_addr = '0;

    logic         req_a, req_b, wf_a, wf_b;
    logic [31:0]  addr_a, addr_b;
    logic [63:0]  rdata_a, rdata_b;
    logic [127:0] ip_a, ip_b;
    logic [1:0]   v_a, v_b;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]  pb_a, pr_a, pb_b, pr_b;
`endif

    fetch_unit_nwide #(.FETCH_WIDTH(2), .XLEN(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .jump(jump), .jump_accept(jump_accept),
        .jump_addr(jump_addr), .stop_fetch(stop_fetch), .imem_req(req_a),
        .imem_addr(addr_a), .imem_rdata(rdata_a), .fetch_instr_pc(ip_a),
        .fetch_valid(v_a), .write_fifo(wf_a)
`ifdef FETCH_PERF_CNT_EN
        , .perf_blocks(pb_a), .perf_redirects(pr_a)
`endif
    );

    fetch_unit_nwide #(.FETCH_WIDTH(2), .XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst_n(rst_n), .jump(1'b0), .jump_accept(1'b0),
        .jump_addr(32'h0), .stop_fetch(1'b0), .imem_req(req_b),
        .imem_addr(addr_b), .imem_rdata(rdata_b), .fetch_instr_pc(ip_b),
        .fetch_valid(v_b), .write_fifo(wf_b)
`ifdef FETCH_PERF_CNT_EN
        , .perf_blocks(pb_b), .perf_redirects(pr_b)
`endif
    );

    // 1-cycle memory: instr = addr | 0xA000_0000; garbage when not requested
    always @(posedge clk) begin
        if (req_a) rdata_a <= {(addr_a + 32'd4) | 32'hA000_0000, addr_a | 32'hA000_0000};
        else       rdata_a <= {$urandom, $urandom};
        if (req_b) rdata_b <= {(addr_b + 32'd4) | 32'hA000_0000, addr_b | 32'hA000_0000};
        else       rdata_b <= {$urandom, $urandom};
    end

    int checks = 0;
    int errors = 0;

    // Block-level model, one slot per DUT: next fetch pc, in-flight block,
    // held block, expected write and the contiguity pointer.
    logic [31:0] m_pc [2];
    logic [31:0] fl_pc[2];
    logic [31:0] hd_pc[2];
    logic [31:0] eb   [2];
    logic [31:0] nxt  [2];
    bit          fl_v [2];
    bit          hd_v [2];
    bit          ew   [2];
    int          mblk [2];
    int          mred [2];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_lanes(input logic [31:0] p);
        logic [127:0] r = '0;
        logic [31:0]  b = {p[31:3], 3'b000};
        for (int i = 0; i < 2; i++) begin
            if (i >= int'(p[2])) begin
                r[64*i +: 32]      = b + 32'(4 * i);
                r[64*i + 32 +: 32] = (b + 32'(4 * i)) | 32'hA000_0000;
            end
        end
        return r;
    endfunction

    task automatic model(input int d, input bit r, input bit redir,
                         input logic [31:0] ja, input bit stop, input logic [31:0] rpc);
        bit req;
        ew[d] = 1'b0;
        if (r) begin
            m_pc[d] = rpc; nxt[d] = rpc; fl_v[d] = 1'b0; hd_v[d] = 1'b0;
            mblk[d] = 0; mred[d] = 0;
            return;
        end
        req = !hd_v[d] && !stop && !redir;
        if (redir) begin
            fl_v[d] = 1'b0; hd_v[d] = 1'b0;
            m_pc[d] = ja & ~32'd3; nxt[d] = m_pc[d]; mred[d]++;
            return;
        end
        if (hd_v[d]) begin
            if (!stop) begin ew[d] = 1'b1; eb[d] = hd_pc[d]; hd_v[d] = 1'b0; end
        end else if (fl_v[d]) begin
            if (!stop) begin ew[d] = 1'b1; eb[d] = fl_pc[d]; end
            else begin hd_v[d] = 1'b1; hd_pc[d] = fl_pc[d]; end
        end
        fl_v[d] = req;
        if (req) begin
            fl_pc[d] = m_pc[d];
            m_pc[d]  = {m_pc[d][31:3], 3'b000} + 32'd8;
        end
        if (ew[d]) mblk[d]++;
    endtask

    task automatic post(input int d, input bit r, input logic wf,
                        input logic [127:0] ip, input logic [1:0] v);
        string n = (d == 0) ? "a" : "b";
        chk({"write_fifo_", n}, wf, ew[d]);
        if (r) begin
            chk({"rst_data_", n}, ip, 128'h0);
            chk({"rst_valid_", n}, v, 2'b00);
        end
        if (ew[d]) begin
            chk({"lanes_", n}, ip, exp_lanes(eb[d]));
            chk({"mask_", n}, v, eb[d][2] ? 2'b10 : 2'b11);
            chk({"contig_", n}, eb[d] & ~32'd3, nxt[d]);
            nxt[d] = {eb[d][31:3], 3'b000} + 32'd8;
        end
    endtask

    task automatic step(input bit r, input bit j, input bit acc,
                        input logic [31:0] ja, input bit s);
        bit er;
        rst_n = !r; jump = j; jump_accept = acc; jump_addr = ja; stop_fetch = s;
        @(negedge clk);
        if (!r) begin
            er = !hd_v[0] && !s && !(j && acc);
            chk("imem_req_a", req_a, er);
            if (er) chk("imem_addr_a", addr_a, {m_pc[0][31:3], 3'b000});
            chk("imem_req_b", req_b, !hd_v[1]);
            if (!hd_v[1]) chk("imem_addr_b", addr_b, {m_pc[1][31:3], 3'b000});
        end
        model(0, r, j && acc, ja, s, 32'h0000_0000);
        model(1, r, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFF8);
        @(posedge clk);
        #1;
        post(0, r, wf_a, ip_a, v_a);
        post(1, r, wf_b, ip_b, v_b);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_blocks_a", pb_a, mblk[0]);
        chk("perf_redirects_a", pr_a, mred[0]);
        chk("perf_blocks_b", pb_b, mblk[1]);
`endif
    endtask

    initial begin
        bit r, s, j, acc;
        logic [31:0] ja;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h106, 0);
        repeat (4) step(0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 32'h500, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 1);
        step(0, 1, 1, 32'h200, 1);
        step(0, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h40, 0);
        repeat (6) step(0, 0, 0, 0, 0);
        repeat (400) begin
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 99) < 30);
            j   = ($urandom_range(0, 99) < 15);
            acc = $urandom_range(0, 1) != 0;
            ja  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(r, j, acc, ja, s);
        end
        repeat (4) step(0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
